// File: rtl/urna_pkg.sv
// urna_pkg: shared definitions for the parametrised ballot box.
//   state_e  - FSM state encoding (IDLE, ENTRY, REVIEW, CLOSED)
//   DIGIT_W  - width of one BCD digit
//   is_bcd() - true when a 4-bit digit is a valid BCD value (0..9)
package urna_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        REVIEW,
        CLOSED
    } state_e;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/urna_code_matcher.sv
// urna_code_matcher: combinational lookup of an entered code against the
// candidate code table.
//   code_i       - entered code, CODE_LEN packed BCD digits
//   cand_codes_i - NUM_CAND packed codes, candidate 0 in the LSBs
//   hit_o        - code equals one of the candidate codes
//   idx_o        - binary index of the matching candidate (0 when no hit)
module urna_code_matcher
    import urna_pkg::*;
#(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned CODE_LEN = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_CAND + 1)
) (
    input  logic [DIGIT_W*CODE_LEN-1:0]          code_i,
    input  logic [NUM_CAND*DIGIT_W*CODE_LEN-1:0] cand_codes_i,
    output logic                                 hit_o,
    output logic [IDX_W-1:0]                     idx_o
);

    localparam int unsigned CODE_W = DIGIT_W * CODE_LEN;

    // Codes are distinct, so at most one entry can match; the first match wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (!hit_o && (cand_codes_i[i*CODE_W +: CODE_W] == code_i)) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/urna_param.sv
// urna_param: parametrised ballot box. Collects a CODE_LEN-digit BCD code,
// holds it for review, and on confirm tallies the candidate (or a null vote)
// in saturating counters.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   digit_i       - BCD digit, taken when valid_i=1
//   valid_i       - one-cycle digit strobe
//   confirm_i     - one-cycle strobe, commit the reviewed vote
//   cancel_i      - one-cycle strobe, abort the current entry
//   finish_i      - level, session closed while high
//   clear_i       - clears all tallies, only while closed
//   sel_i         - readout index (NUM_CAND selects the null counter)
//   count_o       - tally selected by sel_i, 0 when out of range
//   total_o       - number of confirmed ballots (wrapping)
//   status_o      - one-cycle pulse after a vote is recorded
//   review_o      - code complete, awaiting confirm/cancel
//   is_null_o     - during review: the code will count as null
//   ovf_o         - sticky, some counter hit saturation
module urna_param
    import urna_pkg::*;
#(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned CODE_LEN = 4,
    parameter int unsigned CNT_W    = 8,
    parameter logic [NUM_CAND*DIGIT_W*CODE_LEN-1:0] CAND_CODES =
        {16'h3504, 16'h3472, 16'h3485, 16'h3494}
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [DIGIT_W-1:0]                    digit_i,
    input  logic                                  valid_i,
    input  logic                                  confirm_i,
    input  logic                                  cancel_i,
    input  logic                                  finish_i,
    input  logic                                  clear_i,
    input  logic [$clog2(NUM_CAND+1)-1:0]         sel_i,
    output logic [CNT_W-1:0]                      count_o,
    output logic [CNT_W+$clog2(NUM_CAND+1)-1:0]   total_o,
    output logic                                  status_o,
    output logic                                  review_o,
    output logic                                  is_null_o,
    output logic                                  ovf_o
);

    localparam int unsigned SEL_W  = $clog2(NUM_CAND + 1);
    localparam int unsigned TOT_W  = CNT_W + SEL_W;
    localparam int unsigned CODE_W = DIGIT_W * CODE_LEN;
    localparam int unsigned DCNT_W = $clog2(CODE_LEN + 1);

    state_e              state_q;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_d;
    logic [DCNT_W-1:0]   dcnt_q;
    logic                bad_q;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND+1];
    logic [TOT_W-1:0]    total_q;
    logic                status_q;
    logic                ovf_q;

    logic                hit;
    logic [SEL_W-1:0]    idx;
    logic                null_vote;
    logic [SEL_W-1:0]    tgt;
    logic                last_digit;

    urna_code_matcher #(
        .NUM_CAND (NUM_CAND),
        .CODE_LEN (CODE_LEN),
        .IDX_W    (SEL_W)
    ) u_matcher (
        .code_i       (code_q),
        .cand_codes_i (CAND_CODES),
        .hit_o        (hit),
        .idx_o        (idx)
    );

    always_comb begin
        // Shift the new digit in at the LSB end; the first digit ends up as the MSD.
        code_d     = CODE_W'({code_q, digit_i});
        last_digit = (dcnt_q == DCNT_W'(CODE_LEN - 1));
        null_vote  = !hit || bad_q;
        tgt        = null_vote ? SEL_W'(NUM_CAND) : idx;
    end

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i <= NUM_CAND; i++) begin
            if (sel_i == SEL_W'(i)) begin
                count_o = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            code_q   <= '0;
            dcnt_q   <= '0;
            bad_q    <= 1'b0;
            for (int unsigned i = 0; i <= NUM_CAND; i++) begin
                cnt_q[i] <= '0;
            end
            total_q  <= '0;
            status_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            status_q <= 1'b0;
            if (state_q == CLOSED) begin
                if (clear_i) begin
                    for (int unsigned i = 0; i <= NUM_CAND; i++) begin
                        cnt_q[i] <= '0;
                    end
                    total_q <= '0;
                    ovf_q   <= 1'b0;
                end
                if (!finish_i) begin
                    state_q <= IDLE;
                end
            end else if (finish_i) begin
                state_q <= CLOSED;
                code_q  <= '0;
                dcnt_q  <= '0;
                bad_q   <= 1'b0;
            end else if (cancel_i) begin
                state_q <= IDLE;
                code_q  <= '0;
                dcnt_q  <= '0;
                bad_q   <= 1'b0;
            end else if (confirm_i) begin
                if (state_q == REVIEW) begin
                    for (int unsigned i = 0; i <= NUM_CAND; i++) begin
                        if (tgt == SEL_W'(i)) begin
                            if (cnt_q[i] == '1) begin
                                ovf_q <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    total_q  <= total_q + 1'b1;
                    status_q <= 1'b1;
                    state_q  <= IDLE;
                    code_q   <= '0;
                    dcnt_q   <= '0;
                    bad_q    <= 1'b0;
                end
            end else if (valid_i && (state_q != REVIEW)) begin
                code_q <= code_d;
                dcnt_q <= dcnt_q + DCNT_W'(1);
                if (!is_bcd(digit_i)) begin
                    bad_q <= 1'b1;
                end
                state_q <= last_digit ? REVIEW : ENTRY;
            end
        end
    end

    assign total_o   = total_q;
    assign status_o  = status_q;
    assign review_o  = (state_q == REVIEW);
    assign is_null_o = (state_q == REVIEW) && null_vote;
    assign ovf_o     = ovf_q;

endmodule
